// File: rtl/frame_bbox_scan.sv
`default_nettype none
// ============================================================================
//  Module   : frame_bbox_scan
//  Purpose  : Scans one WIDTH x HEIGHT RGB444 frame from a synchronous frame
//             buffer at one pixel per clock. Each pixel is classified against
//             a colour threshold. The module returns the bounding box and the
//             count of matching pixels through a start/done/ack handshake.
//  Ports    : clk, reset (async, active-low)
//             start, ack          - sequencer handshake inputs
//             rd_addr, rd_data    - frame buffer read port (1-clock latency)
//             busy, done, found   - status
//             x_min/x_max/y_min/y_max, hit_count - results, stable between
//                                   successive DONE entries
//  Options  : FRAME_BBOX_RUN_FILTER_EN - when defined, a pixel is counted only
//             if the pixel to its left in the same row also matched.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_bbox_scan #(
   parameter int         WIDTH  = 320,
   parameter int         HEIGHT = 240,
   parameter logic [3:0] R_MIN  = 4'hA,
   parameter logic [3:0] G_MAX  = 4'h5,
   parameter logic [3:0] B_MAX  = 4'h5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ack,
   output logic [16:0] rd_addr,
   input  logic [11:0] rd_data,
   output logic        busy,
   output logic        done,
   output logic        found,
   output logic [8:0]  x_min,
   output logic [8:0]  x_max,
   output logic [8:0]  y_min,
   output logic [8:0]  y_max,
   output logic [16:0] hit_count
);

   localparam logic [8:0]  c_XLAST        = 9'(WIDTH - 1);
   localparam logic [16:0] c_ADDR_PRELAST = 17'(WIDTH * HEIGHT - 2);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SCAN    = 3'd1,
      S_DRAIN   = 3'd2,
      S_DONE    = 3'd3,
      S_ACKWAIT = 3'd4
   } state_t;

   state_t      r_state, w_next;
   logic        w_scan_start;   // IDLE -> SCAN this edge
   logic        w_load;         // DRAIN -> DONE this edge, results latch

   logic [8:0]  r_x, r_y;       // coordinates of the address being issued
   logic [8:0]  r_xd, r_yd;     // coordinates aligned with rd_data
   logic        r_av;           // rd_addr holds an address of this scan
   logic        r_dv;           // rd_data holds a pixel of this scan

   logic [8:0]  r_wxmin, r_wxmax, r_wymin, r_wymax;
   logic [16:0] r_wcnt;

   logic        w_match;
   logic        w_hit;

   assign w_match = (rd_data[11:8] >= R_MIN) &&
                    (rd_data[7:4]  <= G_MAX) &&
                    (rd_data[3:0]  <= B_MAX);

`ifdef FRAME_BBOX_RUN_FILTER_EN
   // Match flag of the previous pixel in the same row; cleared at row end so
   // column 0 can never qualify.
   logic r_prev;

   assign w_hit = r_dv && w_match && r_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prev <= 1'b0;
      end else if (w_scan_start) begin
         r_prev <= 1'b0;
      end else if (r_dv) begin
         r_prev <= w_match && (r_xd != c_XLAST);
      end
   end
`else
   assign w_hit = r_dv && w_match;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_scan_start = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next       = S_SCAN;
               w_scan_start = 1'b1;
            end
         end
         S_SCAN: begin
            // Leave on the edge that issues the final address.
            if (rd_addr == c_ADDR_PRELAST) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            // Wait until the last address has been read and its pixel folded in.
            if (!r_av && !r_dv) begin
               w_next = S_DONE;
               w_load = 1'b1;
            end
         end
         S_DONE: begin
            if (ack) w_next = S_ACKWAIT;
         end
         S_ACKWAIT: begin
            // Only ack gates the return; a start level still high in IDLE
            // launches the next scan, giving back-to-back operation.
            if (!ack) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- address / coordinates
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_addr <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_av    <= 1'b0;
      end else begin
         r_av <= w_scan_start || (r_state == S_SCAN);
         if (w_scan_start) begin
            rd_addr <= '0;
            r_x     <= '0;
            r_y     <= '0;
         end else if (r_state == S_SCAN) begin
            rd_addr <= rd_addr + 17'd1;
            if (r_x == c_XLAST) begin
               r_x <= '0;
               r_y <= r_y + 9'd1;
            end else begin
               r_x <= r_x + 9'd1;
            end
         end
      end
   end

   // ---------------------------------------------------------------- pixel pipeline
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_xd    <= '0;
         r_yd    <= '0;
         r_dv    <= 1'b0;
         r_wxmin <= 9'h1FF;
         r_wxmax <= '0;
         r_wymin <= 9'h1FF;
         r_wymax <= '0;
         r_wcnt  <= '0;
      end else begin
         r_xd <= r_x;
         r_yd <= r_y;
         r_dv <= r_av;
         if (w_scan_start) begin
            r_wxmin <= 9'h1FF;
            r_wxmax <= '0;
            r_wymin <= 9'h1FF;
            r_wymax <= '0;
            r_wcnt  <= '0;
         end else if (w_hit) begin
            if (r_xd < r_wxmin) r_wxmin <= r_xd;
            if (r_xd > r_wxmax) r_wxmax <= r_xd;
            if (r_yd < r_wymin) r_wymin <= r_yd;
            if (r_yd > r_wymax) r_wymax <= r_yd;
            r_wcnt <= r_wcnt + 17'd1;
         end
      end
   end

   // ---------------------------------------------------------------- status and results
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         found     <= 1'b0;
         x_min     <= '0;
         x_max     <= '0;
         y_min     <= '0;
         y_max     <= '0;
         hit_count <= '0;
      end else begin
         if (w_scan_start) busy <= 1'b1;
         if (w_load) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            found     <= (r_wcnt != 17'd0);
            hit_count <= r_wcnt;
            // With no hits the min registers still hold 1FF; report zeros.
            x_min     <= (r_wcnt != 17'd0) ? r_wxmin : 9'd0;
            x_max     <= (r_wcnt != 17'd0) ? r_wxmax : 9'd0;
            y_min     <= (r_wcnt != 17'd0) ? r_wymin : 9'd0;
            y_max     <= (r_wcnt != 17'd0) ? r_wymax : 9'd0;
         end
         if ((r_state == S_DONE) && ack) done <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_frame_bbox_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_bbox_scan
//  Purpose  : Directed, table-driven bench for frame_bbox_scan on a reduced
//             20x12 frame, with hand-written handshake and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_bbox_scan;

   localparam int W = 20;
   localparam int H = 12;
   localparam int N = W * H;

   logic        clk;
   logic        reset;
   logic        start;
   logic        ack;
   logic [16:0] rd_addr;
   logic [11:0] rd_data;
   logic        busy, done, found;
   logic [8:0]  x_min, x_max, y_min, y_max;
   logic [16:0] hit_count;

   logic [11:0] mem [0:N-1];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          pat;
      logic        fnd;
      logic [8:0]  xmn;
      logic [8:0]  xmx;
      logic [8:0]  ymn;
      logic [8:0]  ymx;
      logic [16:0] cnt;
   } vec_t;

   vec_t vecs [6];

   frame_bbox_scan #(
      .WIDTH (W),
      .HEIGHT(H),
      .R_MIN (4'hA),
      .G_MAX (4'h5),
      .B_MAX (4'h5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .ack      (ack),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .busy     (busy),
      .done     (done),
      .found    (found),
      .x_min    (x_min),
      .x_max    (x_max),
      .y_min    (y_min),
      .y_max    (y_max),
      .hit_count(hit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous frame buffer: data for an address appears one clock later.
   always @(posedge clk)
      rd_data <= (int'(rd_addr) < N) ? mem[int'(rd_addr)] : 12'h000;

   function automatic vec_t mk(int p, logic f, int a, int b, int c, int d, int e);
      vec_t v;
      v.pat = p;
      v.fnd = f;
      v.xmn = 9'(a);
      v.xmx = 9'(b);
      v.ymn = 9'(c);
      v.ymx = 9'(d);
      v.cnt = 17'(e);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_px(input int x, input int y, input logic [11:0] v);
      mem[y * W + x] = v;
   endtask

   task automatic fill(input int p);
      for (int i = 0; i < N; i++) mem[i] = 12'h000;
      case (p)
         1: set_px(17, 10, 12'hF00);
         2: for (int y = 0; y < 5; y++)
               for (int x = 10; x < 20; x++) set_px(x, y, 12'hF00);
         3: begin
               set_px(0, 0, 12'hF00);
               set_px(W - 1, H - 1, 12'hF00);
            end
         4: begin
               set_px(5, 3, 12'hA55);   // exactly on every threshold: match
               set_px(6, 3, 12'h955);   // red one below minimum
               set_px(7, 3, 12'hA65);   // green one above maximum
               set_px(8, 3, 12'hA56);   // blue one above maximum
            end
         5: begin
               set_px(19, 6, 12'hA55);  // end of a row ...
               set_px(0, 7, 12'hA55);   // ... and start of the next
               set_px(3, 7, 12'hA55);
               set_px(4, 7, 12'hA55);
            end
         default: ;
      endcase
   endtask

   task automatic check_result(input int idx);
      chk($sformatf("v%0d_found", idx),     32'(found),     32'(vecs[idx].fnd));
      chk($sformatf("v%0d_x_min", idx),     32'(x_min),     32'(vecs[idx].xmn));
      chk($sformatf("v%0d_x_max", idx),     32'(x_max),     32'(vecs[idx].xmx));
      chk($sformatf("v%0d_y_min", idx),     32'(y_min),     32'(vecs[idx].ymn));
      chk($sformatf("v%0d_y_max", idx),     32'(y_max),     32'(vecs[idx].ymx));
      chk($sformatf("v%0d_hit_count", idx), 32'(hit_count), 32'(vecs[idx].cnt));
   endtask

   // Counts edges after E0 until done is seen; n0 is the edge count already
   // elapsed. Optionally pokes start/ack mid-scan, which must be ignored.
   task automatic wait_done(input int n0, input bit disturb, output int n);
      n = n0;
      for (int k = 0; k < N + 50; k++) begin
         @(posedge clk);
         n++;
         #1;
         if (n == 5) chk("addr_after_e5", 32'(rd_addr), 32'd5);
         if (disturb && n == 40) begin start = 1'b1; ack = 1'b1; end
         if (disturb && n == 41) begin start = 1'b0; ack = 1'b0; end
         if (done) break;
      end
   endtask

   task automatic run_scan(input bit disturb);
      int n;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_rise", 32'(busy), 32'd1);
      chk("addr_after_e0", 32'(rd_addr), 32'd0);
      wait_done(0, disturb, n);
      chk("done_latency", 32'(n), 32'(N + 2));
      chk("busy_fall_with_done", 32'(busy), 32'd0);
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1;
      chk("done_fall", 32'(done), 32'd0);
      @(negedge clk);
      ack = 1'b0;
   endtask

   initial begin
      int  n;
      bit  reached;

`ifdef FRAME_BBOX_RUN_FILTER_EN
      vecs[0] = mk(0, 1'b0,  0,  0, 0,  0,  0);
      vecs[1] = mk(1, 1'b0,  0,  0, 0,  0,  0);
      vecs[2] = mk(2, 1'b1, 11, 19, 0,  4, 45);
      vecs[3] = mk(3, 1'b0,  0,  0, 0,  0,  0);
      vecs[4] = mk(4, 1'b0,  0,  0, 0,  0,  0);
      vecs[5] = mk(5, 1'b1,  4,  4, 7,  7,  1);
`else
      vecs[0] = mk(0, 1'b0,  0,  0,  0,  0,  0);
      vecs[1] = mk(1, 1'b1, 17, 17, 10, 10,  1);
      vecs[2] = mk(2, 1'b1, 10, 19,  0,  4, 50);
      vecs[3] = mk(3, 1'b1,  0, 19,  0, 11,  2);
      vecs[4] = mk(4, 1'b1,  5,  5,  3,  3,  1);
      vecs[5] = mk(5, 1'b1,  0, 19,  6,  7,  4);
`endif

      start = 1'b0;
      ack   = 1'b0;
      reset = 1'b1;
      fill(0);
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_found",     32'(found),     32'd0);
      chk("rst_rd_addr",   32'(rd_addr),   32'd0);
      chk("rst_hit_count", 32'(hit_count), 32'd0);
      chk("rst_bounds",    32'({x_min, x_max, y_min}), 32'd0);
      chk("rst_y_max",     32'(y_max),     32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Table-driven patterns; vector 1 also pokes start/ack during SCAN.
      for (int i = 0; i < 6; i++) begin
         fill(vecs[i].pat);
         run_scan(i == 1);
         check_result(i);
         do_ack();
      end

      // ack held for three clocks in DONE: a single done fall, no re-entry.
      fill(1);
      run_scan(1'b0);
      @(negedge clk);
      ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("ack_hold_done_low", 32'(done), 32'd0);
         chk("ack_hold_busy_low", 32'(busy), 32'd0);
      end
      @(negedge clk);
      ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("ack_hold_idle_done", 32'(done), 32'd0);
      chk("ack_hold_idle_busy", 32'(busy), 32'd0);
      check_result(1);

      // start held high: back-to-back scans with identical results.
      fill(2);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("held_busy_rise", 32'(busy), 32'd1);
      wait_done(0, 1'b0, n);
      chk("held_done_latency1", 32'(n), 32'(N + 2));
      check_result(2);
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1;
      chk("held_done_fall", 32'(done), 32'd0);
      @(negedge clk);
      ack = 1'b0;
      @(posedge clk);
      #1;
      chk("turnaround_busy_a1", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("turnaround_busy_a2", 32'(busy), 32'd1);
      repeat (50) @(posedge clk);
      #1;
      chk("held_results_stable_cnt", 32'(hit_count), 32'(vecs[2].cnt));
      chk("held_results_stable_xmin", 32'(x_min), 32'(vecs[2].xmn));
      wait_done(50, 1'b0, n);
      chk("held_done_latency2", 32'(n), 32'(N + 2));
      check_result(2);
      @(negedge clk);
      start = 1'b0;
      do_ack();

      // Reset in the middle of a scan.
      fill(3);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      reached = 1'b0;
      for (int k = 0; k < N + 10; k++) begin
         if (rd_addr == 17'd100) begin
            reached = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("midscan_addr_reached", 32'(reached), 32'd1);
      reset = 1'b0;
      #1;
      chk("midrst_busy",      32'(busy),      32'd0);
      chk("midrst_done",      32'(done),      32'd0);
      chk("midrst_rd_addr",   32'(rd_addr),   32'd0);
      chk("midrst_hit_count", 32'(hit_count), 32'd0);
      chk("midrst_found",     32'(found),     32'd0);
      @(negedge clk);
      reset = 1'b1;
      run_scan(1'b0);
      check_result(3);
      do_ack();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
